// File: rtl/maple_port_scheduler.sv
// Round-robin scheduler sharing one Maple transfer engine between ports A-D.
// Optional BUSY timeout/abort enabled by defining MAPLE_SCHED_TIMEOUT_EN.
module maple_port_scheduler #(
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       eng_done,
    output logic [3:0] grant,
    output logic [1:0] port_sel,
    output logic       eng_start,
    output logic       eng_abort,
    output logic       xfer_done,
    output logic       xfer_err,
    output logic       busy
);

`ifdef MAPLE_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    // Terminal is one below TIMEOUT_CYCLES-1 so abort lands TIMEOUT_CYCLES after start
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES < 2) ? 0 : TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RESP,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [1:0]       win;
    logic             win_vld;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_hit;

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign to_hit  = TO_EN && (cnt_q >= TO_LAST);

    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!win_vld && req[ptr_q - 2'(k)]) begin
                win     = ptr_q - 2'(k);
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (win_vld) begin
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    ptr_d   = win - 2'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (eng_done) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                grant_d = 4'b0000;
                sel_d   = 2'd0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        eng_start = (state_q == S_START);
        xfer_done = (state_q == S_RESP);
        xfer_err  = (state_q == S_RESP) && err_q;
        eng_abort = (state_q == S_RESP) && err_q;
        busy      = (state_q != S_IDLE);
    end

    assign grant    = grant_q;
    assign port_sel = sel_q;

endmodule

// File: tb/tb_maple_port_scheduler.sv
// Scoreboard bench for maple_port_scheduler with randomized transfers.
// Expected results come from a transaction-level round-robin model.
module tb_maple_port_scheduler;

    localparam int GAP  = 3;
    localparam int TOC  = 20;
    localparam int GEFF = (GAP == 0) ? 1 : GAP;
`ifdef MAPLE_SCHED_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       eng_done;
    logic [3:0] grant;
    logic [1:0] port_sel;
    logic       eng_start;
    logic       eng_abort;
    logic       xfer_done;
    logic       xfer_err;
    logic       busy;

    maple_port_scheduler #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TOC),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .eng_done (eng_done),
        .grant    (grant),
        .port_sel (port_sel),
        .eng_start(eng_start),
        .eng_abort(eng_abort),
        .xfer_done(xfer_done),
        .xfer_err (xfer_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] g;
        logic [1:0] ps;
        logic       err;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mptr = 3;
    int   idle_at = 0;

    logic [3:0] rr_exp [5] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Round-robin reference: scan downward from the pointer, wrap mod 4
    function automatic int arb(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (mptr - k + 4) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (xfer_done === 1'b1) begin
                chk("xfer_done_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("done_cycle", cyc, mon_e.at);
                    chk("done_grant", grant, mon_e.g);
                    chk("done_port_sel", port_sel, mon_e.ps);
                    chk("done_err", xfer_err, mon_e.err);
                    chk("done_abort", eng_abort, mon_e.err);
                end
            end else begin
                chk("abort_without_done", eng_abort, 0);
            end
        end
    end

    task automatic run_xfer(input logic [3:0] r, input int d,
                            input bit spur, input bit drop,
                            output int td, output logic [3:0] g);
        int   es;
        int   s;
        int   w;
        exp_t e;
        req = r;
        es  = ((cyc > idle_at) ? cyc : idle_at) + 1;
        do step(); while (eng_start !== 1'b1 && cyc < es + 3);
        chk("start_cycle", cyc, es);
        w    = arb(r);
        mptr = (w + 3) % 4;
        e.g  = 4'(1 << w);
        e.ps = 2'(w);
        g    = grant;
        chk("start_grant", grant, e.g);
        chk("start_port_sel", port_sel, e.ps);
        s     = cyc;
        e.err = TO_ON && (d >= TOC);
        td    = e.err ? s + TOC : s + d + 1;
        e.at  = td;
        sbq.push_back(e);
        if (spur) begin
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
        end
        if (drop) begin
            if (cyc == s) step();
            req = 4'($urandom);
        end
        if (!e.err) begin
            while (cyc < s + d) step();
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
        end
        while (cyc < td) step();
        idle_at = td + GEFF + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         td;
        int         d;
        int         k;
        bit         sp;
        bit         dr;
        logic [3:0] g;
        logic [3:0] r;

        rst      = 1'b1;
        req      = 4'b0000;
        eng_done = 1'b0;
        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_port_sel", port_sel, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_abort", eng_abort, 0);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_xfer_err", xfer_err, 0);
        chk("rst_busy", busy, 0);
        rst     = 1'b0;
        idle_at = cyc;

        for (int i = 0; i < 5; i++) begin
            run_xfer(4'hF, 5, 1'b0, 1'b0, td, g);
            chk("rr_sequence", g, rr_exp[i]);
        end

        run_xfer(4'b0010, 10, 1'b0, 1'b0, td, g);
        req = 4'b0000;
        while (cyc < td + GEFF) step();
        chk("gap_busy_high", busy, 1);
        chk("gap_grant_clear", grant, 0);
        step();
        chk("idle_busy_low", busy, 0);

        run_xfer(4'b0100, 6, 1'b1, 1'b0, td, g);
        run_xfer(4'b1000, 4, 1'b0, 1'b1, td, g);
        run_xfer(4'b0001, TOC + 5, 1'b0, 1'b0, td, g);
        run_xfer(4'b0001, TOC - 1, 1'b0, 1'b0, td, g);
        run_xfer(4'b0001, TOC, 1'b0, 1'b0, td, g);

        req = 4'b1000;
        k   = 0;
        do begin
            step();
            k++;
        end while (eng_start !== 1'b1 && k < 12);
        chk("rst_test_start", eng_start, 1);
        repeat (3) step();
        chk("rst_test_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_port_sel", port_sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_xfer_done", xfer_done, 0);
        chk("midrst_abort", eng_abort, 0);
        mptr = 3;
        step();
        step();
        rst     = 1'b0;
        idle_at = cyc;
        run_xfer(4'hF, 3, 1'b0, 1'b0, td, g);
        chk("post_rst_first_A", g, 4'h8);

        repeat (40) begin
            r  = 4'($urandom_range(1, 15));
            sp = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 3) == 0);
            d  = sp ? int'($urandom_range(2, 24)) : int'($urandom_range(1, 24));
            run_xfer(r, d, sp, dr, td, g);
        end

        k = 0;
        while (sbq.size() > 0 && k < 50) begin
            step();
            k++;
        end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maple_port_scheduler.md
Name: maple_port_scheduler

Overview:
- Time-shares the single Maple bus transfer engine between the four controller ports (A–D).
- Requests come from the SPI command layer.
- Selects one pending port by round-robin, fires the engine, and waits for completion or timeout.
- Enforces an inter-frame gap, then reports the result back to the requester.

Parameters:
- GAP_CYCLES, 50, idle clk cycles between end of one transfer and next arbitration (0 = no gap).
- TIMEOUT_CYCLES, 50000, max clk cycles in BUSY before abort (only with MAPLE_SCHED_TIMEOUT_EN).
- CNT_W, 16, width of gap/timeout counter; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-port transfer request; bit3=A, bit2=B, bit1=C, bit0=D; level, held until matching xfer_done.
- eng_done  input  1  engine finished frame (1-cycle pulse).
- grant  output  4  one-hot owner of engine, same bit order as req; 0 when no owner.
- port_sel  output  2  binary index of granted port (3=A..0=D); engine pin mux select.
- eng_start  output  1  1-cycle start pulse to engine.
- eng_abort  output  1  1-cycle abort pulse to engine on timeout.
- xfer_done  output  1  1-cycle completion pulse; qualifies grant for requester.
- xfer_err  output  1  valid with xfer_done; 1 = timed out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer ptr=3, so port A is highest priority first.
  - Counter 0.
- States:
  - IDLE
    - If |req: pick winner by searching indices ptr, ptr-1, … (mod 4); first set bit wins.
    - Register grant/port_sel; ptr <= (winner-1) mod 4.
    - Go to START.
    - If req=0: stay.
  - START
    - eng_start=1 for exactly this cycle; counter cleared; go to BUSY.
    - eng_start appears 1 cycle after the edge that samples req in IDLE.
  - BUSY
    - Wait for eng_done; eng_done is sampled only in BUSY (a pulse in START is ignored).
    - On eng_done: next cycle xfer_done=1, xfer_err=0, grant still valid; go to GAP.
    - Timeout (feature on): counter increments each BUSY cycle; on reaching TIMEOUT_CYCLES-1 without eng_done, next cycle eng_abort=1, xfer_done=1, xfer_err=1; go to GAP.
    - eng_done and timeout terminal in the same cycle: done wins (xfer_err=0, no abort).
  - GAP
    - grant/port_sel cleared on entry; count GAP_CYCLES cycles; then IDLE.
    - GAP_CYCLES=0: single pass-through cycle in GAP, then IDLE.
- Boundary conditions:
  - req drops during START/BUSY: ignored, transfer completes normally; scheduler never cancels on req.
  - req of the granted port still high in IDLE after xfer_done: treated as a new request, subject to round-robin.
  - Starvation bound: a continuously requesting port is granted within 4 arbitrations.
  - Reset mid-transfer: all outputs drop asynchronously; no xfer_done issued; engine gets no abort (engine shares rst).
  - Counter saturates and never wraps.
- port_sel is always the binary encoding of grant.

Optional Feature:
- MAPLE_SCHED_TIMEOUT_EN
  - Defined: BUSY timeout as above; eng_abort and xfer_err can assert.
  - Undefined: BUSY waits indefinitely for eng_done; eng_abort and xfer_err tied 0; TIMEOUT_CYCLES unused.

Test Plan:
- After reset, req=4'b1111 held, eng_done 5 cycles after each eng_start.
  - Grants are 1000, 0100, 0010, 0001, 1000.
  - Each eng_start is 1 cycle after IDLE sample.
  - Gap between xfer_done and next eng_start = GAP_CYCLES+2.
- req=4'b0010 only, eng_done after 10 cycles.
  - grant=0010, port_sel=1, xfer_done with xfer_err=0.
  - busy low GAP_CYCLES+1 cycles after xfer_done.
- TIMEOUT_EN, TIMEOUT_CYCLES=20, req=4'b0001, no eng_done.
  - eng_abort and xfer_done/xfer_err=1 exactly 20 cycles after eng_start; state returns to IDLE after the gap.
- TIMEOUT_EN, TIMEOUT_CYCLES=20, eng_done on the same cycle as the timeout terminal.
  - xfer_err=0, eng_abort=0.
- req=4'b1000, drop req in BUSY, then eng_done; separately assert rst mid-BUSY.
  - First case: xfer_done still issued.
  - Second case: grant/busy go to 0 immediately, no xfer_done; after release, ptr=3 (A first).
- GAP_CYCLES=0, eng_done pulsed during START.
  - Pulse ignored; transfer completes only on a later eng_done in BUSY.
